// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: per-channel FSM state
// encoding, counter widths and default timing parameters.
package debounce_pkg;

   // Two-bit per-channel debounce state.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CHK_PRESS = 2'd1,
      ST_HELD      = 2'd2,
      ST_CHK_REL   = 2'd3
   } db_state_t;

   localparam int STAB_CNT_W       = 8;
   localparam int LONG_CNT_W       = 16;
   localparam int DEF_STABLE_TICKS = 4;
   localparam int DEF_LONG_TICKS   = 256;

   // True when a tick parameter lies inside 1..max_val.
   function automatic logic ticks_in_range(input int val, input int max_val);
      return (val >= 1) && (val <= max_val);
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounce channel: 2-flop synchronizer, press/release FSM with a
// saturating stability counter and, when BUTTON_DEBOUNCER_LONG_PRESS_EN is
// defined, a saturating long-press hold counter.
module debounce_cell
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_long
);

   localparam logic [STAB_CNT_W-1:0] STABLE_LAST = STAB_CNT_W'(STABLE_TICKS - 1);

   // Out-of-range timing parameters are rejected at elaboration.
   if (!ticks_in_range(STABLE_TICKS, 255) || !ticks_in_range(LONG_TICKS, 65535)) begin : g_bad_param
      $error("debounce_cell: STABLE_TICKS or LONG_TICKS out of range");
   end

   logic [1:0]            sync_r;
   logic                  sync_s;
   db_state_t             state_r;
   logic [STAB_CNT_W-1:0] cnt_r;
   logic                  level_r;
   logic                  press_r;
   logic                  release_r;

   assign sync_s = sync_r[1];

   // Synchronizer, debounce FSM, stability counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_r    <= 2'b00;
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         level_r   <= 1'b0;
         press_r   <= 1'b0;
         release_r <= 1'b0;
      end else begin
         sync_r    <= {sync_r[0], btn_raw};
         press_r   <= 1'b0;
         release_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (sync_s) begin
                  state_r <= ST_CHK_PRESS;
                  cnt_r   <= '0;
               end else begin
                  cnt_r   <= '0;
               end
            end
            ST_CHK_PRESS: begin
               if (!sync_s) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= '0;
               end else if (tick) begin
                  if (cnt_r >= STABLE_LAST) begin
                     state_r <= ST_HELD;
                     cnt_r   <= '0;
                     level_r <= 1'b1;
                     press_r <= 1'b1;
                  end else if (cnt_r != {STAB_CNT_W{1'b1}}) begin
                     cnt_r   <= cnt_r + 8'd1;
                  end else begin
                     cnt_r   <= cnt_r;
                  end
               end else begin
                  cnt_r   <= cnt_r;
               end
            end
            ST_HELD: begin
               if (!sync_s) begin
                  state_r <= ST_CHK_REL;
                  cnt_r   <= '0;
               end else begin
                  cnt_r   <= '0;
               end
            end
            ST_CHK_REL: begin
               if (sync_s) begin
                  state_r <= ST_HELD;
                  cnt_r   <= '0;
               end else if (tick) begin
                  if (cnt_r >= STABLE_LAST) begin
                     state_r   <= ST_IDLE;
                     cnt_r     <= '0;
                     level_r   <= 1'b0;
                     release_r <= 1'b1;
                  end else if (cnt_r != {STAB_CNT_W{1'b1}}) begin
                     cnt_r     <= cnt_r + 8'd1;
                  end else begin
                     cnt_r     <= cnt_r;
                  end
               end else begin
                  cnt_r   <= cnt_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
               level_r <= 1'b0;
            end
         endcase
      end
   end

   assign btn_level   = level_r;
   assign btn_press   = press_r;
   assign btn_release = release_r;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
   localparam logic [LONG_CNT_W-1:0] LONG_LIMIT = LONG_CNT_W'(LONG_TICKS);
   localparam logic [LONG_CNT_W-1:0] LONG_LAST  = LONG_CNT_W'(LONG_TICKS - 1);

   logic [LONG_CNT_W-1:0] long_cnt_r;
   logic                  long_r;

   // Hold-time counter: counts ticks while the level is high, saturates at
   // LONG_TICKS so the long pulse fires once per hold, clears when released.
   always_ff @(posedge clk) begin
      if (!rst) begin
         long_cnt_r <= '0;
         long_r     <= 1'b0;
      end else begin
         long_r <= 1'b0;
         if ((state_r == ST_HELD) || (state_r == ST_CHK_REL)) begin
            if (tick && (long_cnt_r < LONG_LIMIT)) begin
               long_cnt_r <= long_cnt_r + 16'd1;
               long_r     <= (long_cnt_r == LONG_LAST);
            end else begin
               long_cnt_r <= long_cnt_r;
            end
         end else begin
            long_cnt_r <= '0;
         end
      end
   end

   assign btn_long = long_r;
`else
   assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: NBTN independent debounce_cell
// channels sharing one clock, reset and sample tick.
// Optional feature macro: BUTTON_DEBOUNCER_LONG_PRESS_EN (long-press pulses).
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int NBTN         = 5,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic [NBTN-1:0] btn_in,
   output logic [NBTN-1:0] btn_level,
   output logic [NBTN-1:0] btn_press,
   output logic [NBTN-1:0] btn_release,
   output logic [NBTN-1:0] btn_long
);

   for (genvar gi = 0; gi < NBTN; gi++) begin : g_chan
      debounce_cell #(
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS)
      ) u_cell (
         .clk         (clk),
         .rst         (rst),
         .tick        (tick),
         .btn_raw     (btn_in[gi]),
         .btn_level   (btn_level[gi]),
         .btn_press   (btn_press[gi]),
         .btn_release (btn_release[gi]),
         .btn_long    (btn_long[gi])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer (STABLE_TICKS=4,
// LONG_TICKS=8, tick every 10 clk).
module tb_button_debouncer;

   localparam int NB = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          tick;
   logic [NB-1:0] btn_in;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic [NB-1:0] btn_long;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   int cyc    = 0;
   bit tick_en = 1'b1;
   int div    = 0;

   int press_cnt [NB];
   int rel_cnt   [NB];
   int long_cnt  [NB];
   int lvl_cnt   [NB];
   int press_cyc [NB];
   int rel_cyc   [NB];
   int long_cyc  [NB];

   int b_press [NB];
   int b_rel   [NB];
   int b_long  [NB];
   int b_lvl   [NB];
   int edge_cyc;

   button_debouncer #(
      .NBTN         (NB),
      .STABLE_TICKS (4),
      .LONG_TICKS   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long)
   );

   always #5 clk = ~clk;

   // Cycle counter, advanced at each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   // Tick source (one clk in ten) and output monitor, both on the falling edge.
   initial begin
      for (int i = 0; i < NB; i++) begin
         press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0; lvl_cnt[i] = 0;
         press_cyc[i] = 0; rel_cyc[i] = 0; long_cyc[i] = 0;
      end
      tick = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NB; i++) begin
            if (btn_press[i] === 1'b1)   begin press_cnt[i]++; press_cyc[i] = cyc; end
            if (btn_release[i] === 1'b1) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
            if (btn_long[i] === 1'b1)    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
            if (btn_level[i] === 1'b1)   lvl_cnt[i]++;
         end
         tick = tick_en && (div == 9);
         div  = (div == 9) ? 0 : div + 1;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      for (int i = 0; i < NB; i++) begin
         b_press[i] = press_cnt[i];
         b_rel[i]   = rel_cnt[i];
         b_long[i]  = long_cnt[i];
         b_lvl[i]   = lvl_cnt[i];
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      n_total++;
      assert (obs >= lo && obs <= hi) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   initial begin
      rst    = 1'b0;
      btn_in = 5'b00000;
      wait_clk(5);
      // Reset state
      chk("rst_level",   int'(btn_level),   0);
      chk("rst_press",   int'(btn_press),   0);
      chk("rst_release", int'(btn_release), 0);
      chk("rst_long",    int'(btn_long),    0);
      rst = 1'b1;
      wait_clk(10);

      // Clean press on channel 0, then release
      snap();
      btn_in[0] = 1'b1;
      edge_cyc  = cyc;
      wait_clk(100);
      chk("clean_press_cnt", press_cnt[0] - b_press[0], 1);
      chk_rng("clean_press_delay", press_cyc[0] - edge_cyc, 32, 44);
      chk("clean_level", int'(btn_level[0]), 1);
      chk("clean_no_release", rel_cnt[0] - b_rel[0], 0);
      btn_in[0] = 1'b0;
      wait_clk(60);
      chk("clean_release_cnt", rel_cnt[0] - b_rel[0], 1);
      chk("clean_level_low", int'(btn_level[0]), 0);

      // Bounce on channel 0: toggle every 3 clk for 30 clk, then settle high
      snap();
      for (int i = 0; i < 10; i++) begin
         btn_in[0] = ~btn_in[0];
         wait_clk(3);
      end
      btn_in[0] = 1'b1;
      wait_clk(80);
      chk("bounce_press_cnt", press_cnt[0] - b_press[0], 1);
      chk("bounce_release_cnt", rel_cnt[0] - b_rel[0], 0);
      btn_in[0] = 1'b0;
      wait_clk(60);

      // Glitch on channel 1: high for 25 clk only
      snap();
      btn_in[1] = 1'b1;
      wait_clk(25);
      btn_in[1] = 1'b0;
      wait_clk(60);
      chk("glitch_press_cnt", press_cnt[1] - b_press[1], 0);
      chk("glitch_level_seen", lvl_cnt[1] - b_lvl[1], 0);

      // Reset mid-debounce: channel 0 held, channel 2 in CHK_PRESS
      btn_in[0] = 1'b1;
      wait_clk(60);
      chk("pre_rst_level0", int'(btn_level[0]), 1);
      snap();
      btn_in[2] = 1'b1;
      wait_clk(20);
      rst    = 1'b0;
      btn_in = 5'b00000;
      wait_clk(1);
      chk("midrst_level",   int'(btn_level),   0);
      chk("midrst_press",   int'(btn_press),   0);
      chk("midrst_release", int'(btn_release), 0);
      wait_clk(3);
      rst = 1'b1;
      wait_clk(60);
      chk("midrst_no_press2", press_cnt[2] - b_press[2], 0);
      chk("midrst_no_release0", rel_cnt[0] - b_rel[0], 0);

      // Button held through reset release yields one press
      rst       = 1'b0;
      btn_in[1] = 1'b1;
      wait_clk(5);
      snap();
      rst = 1'b1;
      wait_clk(60);
      chk("held_rst_press", press_cnt[1] - b_press[1], 1);
      btn_in[1] = 1'b0;
      wait_clk(60);

      // Simultaneous press and release on channels 0 and 4
      snap();
      btn_in[0] = 1'b1;
      btn_in[4] = 1'b1;
      wait_clk(100);
      chk("simul_press0", press_cnt[0] - b_press[0], 1);
      chk("simul_press4", press_cnt[4] - b_press[4], 1);
      chk("simul_press_same_cyc", press_cyc[0] - press_cyc[4], 0);
      btn_in[0] = 1'b0;
      btn_in[4] = 1'b0;
      wait_clk(60);
      chk("simul_rel0", rel_cnt[0] - b_rel[0], 1);
      chk("simul_rel4", rel_cnt[4] - b_rel[4], 1);
      chk("simul_rel_same_cyc", rel_cyc[0] - rel_cyc[4], 0);

      // Long press on channel 3, held 200 clk
      snap();
      btn_in[3] = 1'b1;
      wait_clk(200);
      chk("long_press_cnt", press_cnt[3] - b_press[3], 1);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      chk("long_pulse_cnt", long_cnt[3] - b_long[3], 1);
      chk("long_delay", long_cyc[3] - press_cyc[3], 80);
`else
      chk("long_absent", long_cnt[3] - b_long[3], 0);
`endif
      btn_in[3] = 1'b0;
      wait_clk(60);
      chk("long_release_cnt", rel_cnt[3] - b_rel[3], 1);

      // Tick held low: a press never completes until ticks resume
      snap();
      tick_en   = 1'b0;
      btn_in[0] = 1'b1;
      wait_clk(80);
      chk("notick_press_cnt", press_cnt[0] - b_press[0], 0);
      chk("notick_level", int'(btn_level[0]), 0);
      tick_en = 1'b1;
      wait_clk(60);
      chk("tick_resume_press", press_cnt[0] - b_press[0], 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter NBTN, default 5, giving the number of independent push-button channels.
REQ-002 The block SHALL have parameter STABLE_TICKS, default 4, giving the consecutive sample ticks an input must hold a new value before it is accepted; legal range is 1..255.
REQ-003 The block SHALL have parameter LONG_TICKS, default 256, giving the hold duration in ticks for a long-press event; legal range is 1..65535.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port tick, input, 1 bit: a sample enable, one clk wide, produced by the upstream clock-divider stage.
REQ-007 The block SHALL have port btn_in, input, NBTN bits: raw push buttons, asynchronous to clk and bouncing.
REQ-008 The block SHALL have port btn_level, output, NBTN bits: the debounced button level.
REQ-009 The block SHALL have port btn_press, output, NBTN bits: a one-clk pulse per accepted press.
REQ-010 The block SHALL have port btn_release, output, NBTN bits: a one-clk pulse per accepted release.
REQ-011 The block SHALL have port btn_long, output, NBTN bits: a one-clk long-press pulse (see Configuration).

Function
REQ-012 Each btn_in bit SHALL pass through a 2-flop synchronizer clocked every clk, independent of tick.
REQ-013 Each channel SHALL run its own FSM with states IDLE (level 0), CHK_PRESS, HELD (level 1) and CHK_REL.
REQ-014 The FSM SHALL make the following transitions:
- IDLE to CHK_PRESS when the synchronized input is 1.
- HELD to CHK_REL when the synchronized input is 0.
- In these two transitions the stability counter SHALL clear.
REQ-015 In CHK_PRESS or CHK_REL, the counter SHALL behave as follows:
- It SHALL increment only on clk cycles where tick=1 and the synchronized input equals the candidate value.
- A mismatch on any clk SHALL return the FSM to its origin state (IDLE or HELD) and clear the counter.
REQ-016 When a tick arrives with the counter at STABLE_TICKS-1 and the input matching, the FSM SHALL move to HELD (from CHK_PRESS) or IDLE (from CHK_REL).
REQ-017 With STABLE_TICKS=1, the FSM SHALL transition on the first matching tick.
REQ-018 btn_level SHALL be registered and equal 1 exactly while the state is HELD or CHK_REL.
REQ-019 btn_press and btn_release SHALL be registered and high for exactly one clk, in the cycle after the state register enters HELD or IDLE respectively from a CHK state.
REQ-020 If tick is held high continuously, every clk SHALL count as a tick (for fast simulation).
REQ-021 If tick stays low, the FSM SHALL still leave a CHK state on a mismatch but SHALL never complete a transition.
REQ-022 Channels SHALL be fully independent, and simultaneous events on several channels SHALL produce pulses in the same cycle.
REQ-023 Counter width SHALL be 8 bits for stability and 16 bits for long press, and counters SHALL saturate rather than wrap.

Reset
REQ-024 While rst=0 at a clk edge, the block SHALL hold the following values:
- All FSMs IDLE.
- Counters 0.
- Synchronizer flops 0.
- btn_level, btn_press, btn_release and btn_long all 0.
REQ-025 Reset asserted mid-debounce SHALL abort it with no pulse emitted.
REQ-026 A button held through reset release SHALL be debounced normally and SHALL yield one btn_press.

Configuration
REQ-027 With macro BUTTON_DEBOUNCER_LONG_PRESS_EN defined, each channel SHALL count ticks while in HELD or CHK_REL, with this behaviour:
- btn_long SHALL pulse for one clk when the count reaches LONG_TICKS.
- It SHALL pulse at most once per hold.
- The count SHALL clear on entering IDLE.
REQ-028 Without BUTTON_DEBOUNCER_LONG_PRESS_EN, the btn_long port SHALL remain and be tied to 0, and no long-press counter SHALL be built.

Structure
REQ-029 A shared package debounce_pkg SHALL hold the FSM state typedef (2-bit encoding), the counter-width constants, and the default STABLE_TICKS and LONG_TICKS values.
REQ-030 The per-channel synchronizer, FSM and counters SHALL be the sub-module debounce_cell, instantiated NBTN times by button_debouncer via generate.

Verification
All scenarios use STABLE_TICKS=4 and tick every 10 clk.
REQ-031 Clean press: btn_in[0] rises and is held 100 clk -> exactly one btn_press[0] pulse, 2 clk + 3 to 4 ticks after the edge, and btn_level[0]=1 thereafter.
REQ-032 Bounce: btn_in[0] toggles every 3 clk for 30 clk, then settles at 1 -> exactly one btn_press[0] and zero btn_release[0].
REQ-033 Glitch: btn_in[1] is high for 25 clk, then low -> no pulse, and btn_level[1] stays 0.
REQ-034 Reset mid-debounce: rst=0 while channel 2 is in CHK_PRESS -> all outputs 0 on the next clk, and no press pulse after rst returns to 1 with the input low.
REQ-035 Simultaneous: btn_in[0] and btn_in[4] rise in the same cycle -> both btn_press pulses occur in the same clk, followed by matching releases on the falling edge.
REQ-036 Long press: with the macro defined and LONG_TICKS=8, btn_in[3] is held 200 clk -> one btn_long[3] pulse 8 ticks after HELD; without the macro, btn_long stays 0.
